// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the boot-time instruction memory loader.
package imem_loader_pkg;
  localparam int IMEM_ADDR_W = 11;
  localparam int IMEM_DEPTH  = 2048;
  localparam int HDR_BYTES   = 2;
  localparam int CNT_W       = 8 * HDR_BYTES;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_e;
endpackage

// File: rtl/imem_word_packer.sv
// Packs four bytes little-endian into a 32-bit word; o_word already contains
// the byte being pushed so the consumer can capture it in the same cycle.
module imem_word_packer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_push,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_full
);
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (i_clear) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (i_push) begin
      word_d[{cnt_q, 3'b000} +: 8] = i_byte;
      cnt_d = cnt_q + 2'd1;
    end
  end

  assign o_word = word_d;
  assign o_full = i_push && !i_clear && (cnt_q == 2'd3);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a 16-bit word-count header, packs bytes into words and
// writes them to imem, keeping the CPU in reset until the image is complete.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte,
  output logic              o_byte_ready,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [31:0]       o_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_cpu_rst_n
);
  localparam logic [CNT_W:0] MAX_CNT = (CNT_W+1)'(1) << ADDR_W;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  hdr_q, hdr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              xfer, pk_push, pk_clear, pk_full;
  logic [31:0]       pk_word;
  logic [CNT_W:0]    cnt_ext, idx_nxt;

  assign o_byte_ready = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
  assign o_busy       = o_byte_ready || (state_q == WRITE);
  assign o_done       = (state_q == DONE);
  assign o_err        = (state_q == ERR);
  assign o_cpu_rst_n  = (state_q == DONE);
  assign o_we         = we_q;
  assign o_waddr      = waddr_q;
  assign o_wdata      = wdata_q;

  assign xfer    = i_byte_valid && o_byte_ready;
  assign pk_push = xfer && (state_q == DATA);

  imem_word_packer u_packer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (pk_clear),
    .i_push  (pk_push),
    .i_byte  (i_byte),
    .o_word  (pk_word),
    .o_full  (pk_full)
  );

  always_comb begin
    state_d  = state_q;
    hdr_d    = hdr_q;
    idx_d    = idx_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    pk_clear = 1'b0;
    cnt_ext  = {1'b0, i_byte, hdr_q[7:0]};
    idx_nxt  = {{(CNT_W+1-ADDR_W){1'b0}}, idx_q} + (CNT_W+1)'(1);
    case (state_q)
      IDLE, DONE, ERR: begin
        if (i_start) begin
          state_d  = LEN_LO;
          idx_d    = '0;
          pk_clear = 1'b1;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          hdr_d[7:0] = i_byte;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          hdr_d[15:8] = i_byte;
          if (cnt_ext == '0)         state_d = DONE;
          else if (cnt_ext > MAX_CNT) state_d = ERR;
          else                        state_d = DATA;
        end
      end
      DATA: begin
        if (pk_full) begin
          we_d    = 1'b1;
          waddr_d = idx_q;
          wdata_d = pk_word;
          state_d = WRITE;
        end
      end
      WRITE: begin
        // Index stops on the final word so a full-depth image never wraps.
        if (idx_nxt == {1'b0, hdr_q}) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_nxt[ADDR_W-1:0];
          state_d = DATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= IDLE;
      hdr_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end
endmodule
